ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (registered read address, write-first
//  on clk) between two requesters, A and B. Round-robin arbitration with a
//  same-cycle grant. Read data returns one cycle after grant. Sits between two
//  client engines and the RAM instance.
// PARAMETERS
//  DATA_WIDTH  8   RAM word width in bits
//  ADDR_WIDTH  10  RAM address width; depth = 2**ADDR_WIDTH
// PORTS
//  clk        in   1           system clock, rising edge
//  reset_n    in   1           asynchronous active-low reset
//  req_a      in   1           A requests an access this cycle
//  we_a       in   1           A access is a write (1) or a read (0)
//  lock_a     in   1           A keeps ownership after the grant (only with the macro)
//  addr_a     in   ADDR_WIDTH  A address
//  wdata_a    in   DATA_WIDTH  A write data
//  gnt_a      out  1           A access accepted this cycle
//  rvalid_a   out  1           A read data valid
//  rdata_a    out  DATA_WIDTH  A read data; 0 when rvalid_a=0
//  req_b/we_b/lock_b/addr_b/wdata_b/gnt_b/rvalid_b/rdata_b  same as A, for B
//  ram_we     out  1           to RAM we
//  ram_addr   out  ADDR_WIDTH  to RAM addr
//  ram_d      out  DATA_WIDTH  to RAM d
//  ram_q      in   DATA_WIDTH  from RAM q
// BEHAVIOUR
//  - Reset (async, while reset_n=0):
//    - prio=A; state=ARB; rvalid_a=rvalid_b=0.
//    - gnt_*=0, ram_we=0, ram_addr=0, ram_d=0.
//  - Grant logic, combinational from req_* and state/prio:
//    - Only one requester asserts req -> grant it.
//    - Both assert req -> grant the requester named by prio.
//    - Never grant both in the same cycle.
//  - Granted requester drives the RAM: ram_we=we_x, ram_addr=addr_x, ram_d=wdata_x.
//    With no grant: ram_we=0, ram_addr=0, ram_d=0.
//  - Request handshake:
//    - A request is consumed on the clk edge where gnt_x=1.
//    - An ungranted requester holds req/we/addr/wdata stable until granted.
//  - prio update: after any grant, prio points to the other requester (next edge).
//    With no grant, prio holds.
//  - Fairness: with both requesting continuously, the arbiter alternates
//    A,B,A,B,... Neither requester waits more than 1 cycle.
//  - Read latency is 1:
//    - rvalid_x<=gnt_x & ~we_x, registered.
//    - rdata_x = rvalid_x ? ram_q : 0.
//    - Back-to-back reads return in grant order, one per cycle.
//  - Write: takes effect at the grant edge; rvalid_x is not asserted.
//    A read of the same address one cycle later returns the new data.
//  - State machine (the LOCK states are reachable only with the macro):
//    - ARB: normal arbitration.
//    - ARB -> LOCK_A: on gnt_a & lock_a.
//    - ARB -> LOCK_B: on gnt_b & lock_b.
//    - LOCK_x: only x is grantable.
//    - LOCK_x -> ARB: on an edge where x has req_x=1 & lock_x=0 (last access,
//      which is granted), or where req_x=0.
//  - Reset mid-operation: in-flight read data is discarded, rvalid is cleared
//    immediately, and a held lock is released.
// CONFIGURATION
//  - RAM_ARB_LOCK_EN defined: lock_a and lock_b are honoured as described.
//  - Undefined: lock inputs are ignored and state is fixed at ARB.
//    Pure round-robin; ports unchanged.
// TESTING
//  1. Reset: hold reset_n=0 with req_a=req_b=1 -> gnt_*=0, rvalid_*=0, ram_we=0.
//     Release -> gnt_a=1 first.
//  2. Write A addr 0x005 data 0x3C; next cycle read B addr 0x005
//     -> gnt_b=1; next cycle rvalid_b=1, rdata_b=0x3C, rvalid_a=0.
//  3. Both request reads (A addr1, B addr2) held for 4 cycles, prio=A
//     -> grants A,B,A,B; rvalid follows each grant by exactly 1 cycle.
//  4. Only B requests for 3 cycles -> gnt_b=1 every cycle.
//     Then both request -> A granted (prio=A after B grant).
//  5. Read granted, then reset_n pulsed low before the next edge
//     -> rvalid stays 0, and no stale rdata is returned after release.
//  6. With RAM_ARB_LOCK_EN: A holds lock_a=1 for 3 accesses while B requests
//     -> gnt_b=0 throughout. Access with lock_a=0 is granted, then B is granted
//     next. Without the macro -> alternation as in test 3.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between requesters A and B
// using round-robin arbitration with a same-cycle grant. Define RAM_ARB_LOCK_EN to honour lock_a/lock_b.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic                  lock_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic                  lock_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   prio_b_r;
    logic   prio_b_next_s;
    logic   gnt_a_s;
    logic   gnt_b_s;
    logic   rvalid_a_r;
    logic   rvalid_b_r;

`ifndef RAM_ARB_LOCK_EN
    logic   unused_lock_s;
    assign unused_lock_s = lock_a ^ lock_b;
`endif

    // Grant selection: reset forces no grant, a held lock restricts the grant to its owner
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        if (!reset_n) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else begin
            case (state_r)
                ARB: begin
                    if (req_a && req_b) begin
                        if (prio_b_r) begin
                            gnt_b_s = 1'b1;
                        end else begin
                            gnt_a_s = 1'b1;
                        end
                    end else begin
                        gnt_a_s = req_a;
                        gnt_b_s = req_b;
                    end
                end
                LOCK_A: begin
                    gnt_a_s = req_a;
                end
                LOCK_B: begin
                    gnt_b_s = req_b;
                end
                default: begin
                    gnt_a_s = 1'b0;
                    gnt_b_s = 1'b0;
                end
            endcase
        end
    end

    // Next state and next priority
    always_comb begin
        state_next_s  = state_r;
        prio_b_next_s = prio_b_r;
        if (gnt_a_s) begin
            prio_b_next_s = 1'b1;
        end else if (gnt_b_s) begin
            prio_b_next_s = 1'b0;
        end else begin
            prio_b_next_s = prio_b_r;
        end
`ifdef RAM_ARB_LOCK_EN
        case (state_r)
            ARB: begin
                if (gnt_a_s && lock_a) begin
                    state_next_s = LOCK_A;
                end else if (gnt_b_s && lock_b) begin
                    state_next_s = LOCK_B;
                end else begin
                    state_next_s = ARB;
                end
            end
            LOCK_A: begin
                // A dropping req or lock is the end of its locked burst
                if (!req_a || !lock_a) begin
                    state_next_s = ARB;
                end else begin
                    state_next_s = LOCK_A;
                end
            end
            LOCK_B: begin
                if (!req_b || !lock_b) begin
                    state_next_s = ARB;
                end else begin
                    state_next_s = LOCK_B;
                end
            end
            default: begin
                state_next_s = ARB;
            end
        endcase
`else
        state_next_s = ARB;
`endif
    end

    // State, priority and read-valid registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ARB;
            prio_b_r   <= 1'b0;
            rvalid_a_r <= 1'b0;
            rvalid_b_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            prio_b_r   <= prio_b_next_s;
            rvalid_a_r <= gnt_a_s & ~we_a;
            rvalid_b_r <= gnt_b_s & ~we_b;
        end
    end

    // RAM port mux driven by the granted requester
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = {ADDR_WIDTH{1'b0}};
        ram_d    = {DATA_WIDTH{1'b0}};
        if (gnt_a_s) begin
            ram_we   = we_a;
            ram_addr = addr_a;
            ram_d    = wdata_a;
        end else if (gnt_b_s) begin
            ram_we   = we_b;
            ram_addr = addr_b;
            ram_d    = wdata_b;
        end else begin
            ram_we   = 1'b0;
            ram_addr = {ADDR_WIDTH{1'b0}};
            ram_d    = {DATA_WIDTH{1'b0}};
        end
    end

    assign gnt_a    = gnt_a_s;
    assign gnt_b    = gnt_b_s;
    assign rvalid_a = rvalid_a_r;
    assign rvalid_b = rvalid_b_r;
    assign rdata_a  = rvalid_a_r ? ram_q : {DATA_WIDTH{1'b0}};
    assign rdata_b  = rvalid_b_r ? ram_q : {DATA_WIDTH{1'b0}};

endmodule
